// File: rtl/tdc_meas_if.sv
// Command, configuration and result port of the TDC measurement sequencer.
// The master side requests runs and consumes results; the slave side is the sequencer.
interface tdc_meas_if #(
  parameter int CW = 6,
  parameter int SW = 13
);
  logic          cmd_start;
  logic [2:0]    cfg_nsamp_log2;
  logic [3:0]    cfg_settle;
  logic          busy;
  logic          res_valid;
  logic          res_ready;
  logic [SW-1:0] res_sum;
  logic [CW-1:0] res_mean;
  logic [CW-1:0] res_min;
  logic [CW-1:0] res_max;
  logic          err_bubble;

  modport master (
    output cmd_start, cfg_nsamp_log2, cfg_settle, res_ready,
    input  busy, res_valid, res_sum, res_mean, res_min, res_max, err_bubble
  );

  modport slave (
    input  cmd_start, cfg_nsamp_log2, cfg_settle, res_ready,
    output busy, res_valid, res_sum, res_mean, res_min, res_max, err_bubble
  );
endinterface

// File: rtl/tdc_meas_ctrl.sv
// Tapped-delay-line TDC measurement sequencer: launch/settle/sample/recover, 2^k-sample statistics.
// Optional macro TDC_BUBBLE_FIX_EN: tap count becomes popcount instead of leading ones.
//
// state   | meaning
// IDLE    | waiting for cmd_start, line discharged
// LAUNCH  | start edge driven into the delay line (1 cycle)
// SETTLE  | line propagating, S cycles
// SAMPLE  | thermometer code captured at the end of this cycle
// RECOVER | start low, line discharging, S cycles; tap count accumulated in first cycle
// DONE    | result valid, waiting for res_ready
module tdc_meas_ctrl #(
  parameter int N_DELAY = 32,
  parameter int CW      = 6,
  parameter int SW      = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  tdc_meas_if.slave          bus,
  output logic               tdc_start,
  input  logic [N_DELAY-1:0] tdc_code
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    SETTLE  = 3'd2,
    SAMPLE  = 3'd3,
    RECOVER = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [2:0]         k_q;
  logic [3:0]         settle_q;
  logic [3:0]         tmr_q;
  logic [6:0]         smp_q;
  logic               rec_first_q;
  logic [N_DELAY-1:0] code_q;
  logic [SW-1:0]      sum_q;
  logic [CW-1:0]      min_q;
  logic [CW-1:0]      max_q;
  logic               bub_q;

  logic [SW-1:0]      res_sum_q;
  logic [CW-1:0]      res_mean_q;
  logic [CW-1:0]      res_min_q;
  logic [CW-1:0]      res_max_q;
  logic               res_bub_q;

  logic               accept;
  logic               tmr_tc;
  logic               last_smp;
  logic               acc_en;
  logic               done_entry;
  logic [CW-1:0]      tap_cnt;
  logic               code_bubble;
  logic [SW-1:0]      sum_upd;
  logic [CW-1:0]      min_upd;
  logic [CW-1:0]      max_upd;
  logic               bub_upd;
  logic               start_lvl;
  logic               busy_lvl;
  logic               valid_lvl;

  assign accept     = (state_q == IDLE) && bus.cmd_start;
  assign tmr_tc     = (tmr_q == 4'd0);
  assign last_smp   = (smp_q == 7'd0);
  assign acc_en     = (state_q == RECOVER) && rec_first_q;
  assign done_entry = (state_q == RECOVER) && tmr_tc && last_smp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_lvl = 1'b0;
    busy_lvl  = 1'b1;
    valid_lvl = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_lvl = 1'b0;
        if (bus.cmd_start) state_d = LAUNCH;
      end
      LAUNCH: begin
        start_lvl = 1'b1;
        state_d   = SETTLE;
      end
      SETTLE: begin
        start_lvl = 1'b1;
        if (tmr_tc) state_d = SAMPLE;
      end
      SAMPLE: begin
        start_lvl = 1'b1;
        state_d   = RECOVER;
      end
      RECOVER: begin
        if (tmr_tc) state_d = last_smp ? DONE : LAUNCH;
      end
      DONE: begin
        valid_lvl = 1'b1;
        if (bus.res_ready) state_d = IDLE;
      end
      default: begin
        busy_lvl = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // Decoded straight from the async-reset state register, so reset drops the start level at once.
  assign tdc_start     = start_lvl;
  assign bus.busy      = busy_lvl;
  assign bus.res_valid = valid_lvl;

`ifdef TDC_BUBBLE_FIX_EN
  always_comb begin
    tap_cnt = '0;
    for (int i = 0; i < N_DELAY; i++) begin
      tap_cnt = tap_cnt + CW'(code_q[i]);
    end
  end
`else
  always_comb begin
    logic found;
    found   = 1'b0;
    tap_cnt = CW'(N_DELAY);
    for (int i = 0; i < N_DELAY; i++) begin
      if (!found && !code_q[i]) begin
        tap_cnt = CW'(i);
        found   = 1'b1;
      end
    end
  end
`endif

  // A clean code 0..01..1 plus one has no bits in common with itself.
  assign code_bubble = |(code_q & (code_q + N_DELAY'(1)));

  always_comb begin
    sum_upd = sum_q;
    min_upd = min_q;
    max_upd = max_q;
    bub_upd = bub_q;
    if (acc_en) begin
      sum_upd = sum_q + SW'(tap_cnt);
      if (tap_cnt < min_q) min_upd = tap_cnt;
      if (tap_cnt > max_q) max_upd = tap_cnt;
      bub_upd = bub_q | code_bubble;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q         <= '0;
      settle_q    <= 4'd1;
      tmr_q       <= '0;
      smp_q       <= '0;
      rec_first_q <= 1'b0;
      code_q      <= '0;
      sum_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      bub_q       <= 1'b0;
    end else begin
      rec_first_q <= (state_q == SAMPLE);
      if (state_q == SAMPLE) code_q <= tdc_code;

      if (state_q == LAUNCH || state_q == SAMPLE) tmr_q <= settle_q - 4'd1;
      else if (!tmr_tc)                             tmr_q <= tmr_q - 4'd1;

      if (accept) begin
        k_q      <= bus.cfg_nsamp_log2;
        settle_q <= (bus.cfg_settle == 4'd0) ? 4'd1 : bus.cfg_settle;
        smp_q    <= 7'((8'd1 << bus.cfg_nsamp_log2) - 8'd1);
        sum_q    <= '0;
        min_q    <= CW'(N_DELAY);
        max_q    <= '0;
        bub_q    <= 1'b0;
      end else begin
        sum_q <= sum_upd;
        min_q <= min_upd;
        max_q <= max_upd;
        bub_q <= bub_upd;
        if (state_q == RECOVER && tmr_tc && !last_smp) smp_q <= smp_q - 7'd1;
      end
    end
  end

  // With S=1 the final accumulate and DONE entry share an edge, hence the *_upd sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_sum_q  <= '0;
      res_mean_q <= '0;
      res_min_q  <= '0;
      res_max_q  <= '0;
      res_bub_q  <= 1'b0;
    end else if (done_entry) begin
      res_sum_q  <= sum_upd;
      res_mean_q <= CW'(sum_upd >> k_q);
      res_min_q  <= min_upd;
      res_max_q  <= max_upd;
      res_bub_q  <= bub_upd;
    end
  end

  assign bus.res_sum    = res_sum_q;
  assign bus.res_mean   = res_mean_q;
  assign bus.res_min    = res_min_q;
  assign bus.res_max    = res_max_q;
  assign bus.err_bubble = res_bub_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl: scoreboarded results, per-cycle start/valid timing, reset cases.
module tb_tdc_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tdc_start;
  logic [31:0] tdc_code;

  tdc_meas_if #(.CW(6), .SW(13)) bus ();

  tdc_meas_ctrl #(.N_DELAY(32), .CW(6), .SW(13)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .tdc_start (tdc_start),
    .tdc_code  (tdc_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] sum;
    logic [5:0]  mean;
    logic [5:0]  mn;
    logic [5:0]  mx;
    logic        bub;
  } res_t;

  res_t        sb[$];
  logic [31:0] code_tab[128];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int lead_ones(input logic [31:0] c);
    int n = 0;
    while (n < 32 && c[n]) n++;
    return n;
  endfunction

  function automatic int taps(input logic [31:0] c);
`ifdef TDC_BUBBLE_FIX_EN
    return $countones(c);
`else
    return lead_ones(c);
`endif
  endfunction

  function automatic logic [31:0] therm(input int n);
    logic [32:0] t;
    t = (33'd1 << n) - 33'd1;
    return t[31:0];
  endfunction

  task automatic run(input int k, input int s, input int hold);
    int   se, per, total, bad_start, bad_busy, bad_hold, t;
    res_t e, got;
    se  = (s == 0) ? 1 : s;
    per = 2 * se + 2;
    total = per << k;
    e.sum = 0; e.mn = 6'd32; e.mx = 0; e.bub = 0;
    for (int i = 0; i < (1 << k); i++) begin
      t = taps(code_tab[i]);
      e.sum = e.sum + 13'(t);
      if (t < int'(e.mn)) e.mn = 6'(t);
      if (t > int'(e.mx)) e.mx = 6'(t);
      if (code_tab[i] !== therm(lead_ones(code_tab[i]))) e.bub = 1'b1;
    end
    e.mean = 6'(e.sum >> k);
    sb.push_back(e);

    bus.cfg_nsamp_log2 = 3'(k);
    bus.cfg_settle     = 4'(s);
    bus.cmd_start      = 1'b1;
    tdc_code           = code_tab[0];
    @(posedge clk); #1;
    bus.cmd_start      = 1'b0;
    bus.cfg_nsamp_log2 = ~3'(k);
    bus.cfg_settle     = ~4'(s);
    chk("busy_rise", {31'd0, bus.busy}, 32'd1);

    bad_start = 0;
    bad_busy  = 0;
    for (int ed = 1; ed <= total; ed++) begin
      if (tdc_start !== (((ed - 1) % per) < se + 2)) bad_start++;
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b1) bad_busy++;
      @(posedge clk); #1;
      if (ed % per == 0 && ed < total) tdc_code = code_tab[ed / per];
    end
    chk("start_pattern_errs", bad_start, 0);
    chk("early_valid_errs", bad_busy, 0);
    chk("valid_rise", {31'd0, bus.res_valid}, 32'd1);
    chk("start_low_done", {31'd0, tdc_start}, 32'd0);

    bad_hold = 0;
    for (int h = 0; h < hold; h++) begin
      bus.cmd_start = (h == hold / 2);
      @(posedge clk); #1;
      if (bus.res_valid !== 1'b1 || bus.busy !== 1'b1 || bus.res_sum !== e.sum ||
          bus.res_min !== e.mn || bus.res_max !== e.mx) bad_hold++;
    end
    bus.cmd_start = 1'b0;
    if (hold > 0) chk("hold_stable_errs", bad_hold, 0);

    chk("sb_nonempty", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb.size() != 0) begin
      got = sb.pop_front();
      chk("res_sum",    {19'd0, bus.res_sum},    {19'd0, got.sum});
      chk("res_mean",   {26'd0, bus.res_mean},   {26'd0, got.mean});
      chk("res_min",    {26'd0, bus.res_min},    {26'd0, got.mn});
      chk("res_max",    {26'd0, bus.res_max},    {26'd0, got.mx});
      chk("err_bubble", {31'd0, bus.err_bubble}, {31'd0, got.bub});
    end

    bus.res_ready = 1'b1;
    bus.cmd_start = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    bus.cmd_start = 1'b0;
    chk("hs_busy_fall",  {31'd0, bus.busy},      32'd0);
    chk("hs_valid_fall", {31'd0, bus.res_valid}, 32'd0);
    @(posedge clk); #1;
    chk("idle_after_hs", {31'd0, bus.busy},      32'd0);
  endtask

  initial begin
    int n;
    rst_n              = 1'b0;
    bus.cmd_start      = 1'b0;
    bus.cfg_nsamp_log2 = 3'd0;
    bus.cfg_settle     = 4'd1;
    bus.res_ready      = 1'b0;
    tdc_code           = 32'd0;

    #2;
    chk("rst_start_async", {31'd0, tdc_start}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start",  {31'd0, tdc_start},      32'd0);
    chk("rst_busy",   {31'd0, bus.busy},       32'd0);
    chk("rst_valid",  {31'd0, bus.res_valid},  32'd0);
    chk("rst_sum",    {19'd0, bus.res_sum},    32'd0);
    chk("rst_mean",   {26'd0, bus.res_mean},   32'd0);
    chk("rst_min",    {26'd0, bus.res_min},    32'd0);
    chk("rst_max",    {26'd0, bus.res_max},    32'd0);
    chk("rst_bubble", {31'd0, bus.err_bubble}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_start", {31'd0, tdc_start}, 32'd0);
    chk("post_rst_busy",  {31'd0, bus.busy},  32'd0);

    code_tab[0] = 32'h0000FFFF;
    run(0, 1, 0);

    code_tab[0] = 32'h000000FF;
    code_tab[1] = 32'h00000FFF;
    code_tab[2] = 32'h0000FFFF;
    code_tab[3] = 32'h000FFFFF;
    run(2, 3, 0);

    code_tab[0] = 32'h0000FEFF;
    run(0, 2, 0);

    code_tab[0] = 32'h000000FF;
    run(0, 1, 10);

    for (int i = 0; i < 8; i++) begin
      n = int'($urandom_range(0, 32));
      code_tab[i] = therm(n);
      if (i == 5) code_tab[i] = code_tab[i] ^ 32'h0000_0100;
    end
    run(3, 2, 0);

    for (int i = 0; i < 128; i++) code_tab[i] = 32'hFFFFFFFF;
    code_tab[17] = 32'h00000000;
    run(7, 0, 0);

    code_tab[0] = 32'h00000003;
    run(0, 15, 0);

    bus.cfg_nsamp_log2 = 3'd1;
    bus.cfg_settle     = 4'd4;
    bus.cmd_start      = 1'b1;
    tdc_code           = 32'h0000FFFF;
    @(posedge clk); #1;
    bus.cmd_start = 1'b0;
    @(posedge clk); #1;
    chk("mid_settle_start", {31'd0, tdc_start}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_start_drop", {31'd0, tdc_start}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy",  {31'd0, bus.busy},      32'd0);
    chk("mid_rst_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("mid_rst_sum",   {19'd0, bus.res_sum},   32'd0);

    code_tab[0] = 32'h00FFFFFF;
    code_tab[1] = 32'h0000000F;
    run(1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdc_meas_ctrl.md
# tdc_meas_ctrl

Measurement sequencer for the tapped-delay-line TDC. It drives the delay line's start input and samples the 32-tap thermometer code after a programmable settle time. Each sample is converted to a tap count, and the block accumulates 2^k samples into sum, mean, min and max. The result is presented on a valid/ready port, replacing the free-running capture register between the delay line and the output mux.

## Interface
Parameters:
- `N_DELAY`, 32, number of delay taps (width of `tdc_code`)
- `CW`, 6, tap-count width, equal to clog2(N_DELAY+1)
- `SW`, 13, sum width, equal to CW+7

Ports:
- `clk`  in  1  system clock; single clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `cmd_start`  in  1  request a run; accepted only in IDLE
- `cfg_nsamp_log2`  in  3  k; run length is 2^k samples (1..128); latched on accept
- `cfg_settle`  in  4  settle/recover length S in cycles; 0 is treated as 1; latched on accept
- `tdc_start`  out  1  start level to the delay line
- `tdc_code`  in  N_DELAY  thermometer code from the delay line; bit0 is the first tap
- `busy`  out  1  high in every state except IDLE
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts the result
- `res_sum`  out  SW  sum of the tap counts
- `res_mean`  out  CW  res_sum >> k, truncated
- `res_min`  out  CW  smallest tap count in the run
- `res_max`  out  CW  largest tap count in the run
- `err_bubble`  out  1  set if any sample in the run was not of the form 0…01…1

## Operation
- States:
  - IDLE → LAUNCH on `cmd_start`.
  - LAUNCH (1 cycle) → SETTLE.
  - SETTLE (S cycles) → SAMPLE.
  - SAMPLE (1 cycle) → RECOVER.
  - RECOVER (S cycles) → LAUNCH if samples remain, otherwise → DONE.
  - DONE → IDLE on `res_valid && res_ready`.
- `tdc_start` is 1 in LAUNCH, SETTLE and SAMPLE. It is 0 in all other states, which lets the line discharge during RECOVER.
- `tdc_code` is captured into a single register on the edge that ends SAMPLE. The tap count is computed from the captured value and accumulated on the edge that ends the first RECOVER cycle.
- Tap count is the number of consecutive ones starting at bit0, range 0..N_DELAY. This changes under `TDC_BUBBLE_FIX_EN` (see Configuration).
- On accept, the accumulators initialise to sum=0, min=N_DELAY, max=0, bubble=0.
- Result outputs are loaded on DONE entry and held until the next DONE entry.
- Maximum sum is 32·128 = 4096, so the sum never overflows `SW`.
- `cmd_start` is ignored whenever the state is not IDLE, including the cycle in which a DONE handshake completes. It must be reasserted to start a new run.
- `res_ready` is ignored while `res_valid` is 0.
- `cfg_*` changes during a run have no effect on that run.

## Timing
- Reset values: `tdc_start`, `busy` and `res_valid` are 0; `res_sum`, `res_mean`, `res_min`, `res_max` and `err_bubble` are 0; state is IDLE.
- Assertion of `rst_n` low forces `tdc_start` low immediately, without waiting for a clock edge. Any run in progress is discarded.
- `busy` rises on the edge that samples `cmd_start` in IDLE.
- Each sample takes 2S+2 cycles.
- `res_valid` rises exactly 2^k·(2S+2) cycles after the accepting edge.
- `res_valid` stays high and all `res_*` outputs stay stable until the handshake.
- `res_valid` and `busy` fall on the handshake edge; the state is IDLE on the next cycle.
- Minimum back-to-back run spacing is one IDLE cycle.

## Configuration
- `TDC_BUBBLE_FIX_EN` defined: tap count is popcount(`tdc_code`), which tolerates bubbles in the code.
- `TDC_BUBBLE_FIX_EN` undefined: tap count is the number of leading ones (position of the first zero).
- `err_bubble` detection is present in both builds.

## Test plan
- Reset: hold `rst_n` low, then release with `cmd_start`=0. Required: all outputs 0, state IDLE, `tdc_start` never pulses.
- Single sample: S=1, k=0, `tdc_code`=0x0000FFFF. Required: `tdc_start` high for cycles 1–3 after accept; `res_valid` high at cycle 4; sum=mean=min=max=16; `err_bubble`=0.
- Four samples: k=2, codes 0xFF, 0xFFF, 0xFFFF, 0xFFFFF in successive samples. Required: sum=56, mean=14, min=8, max=20.
- Bubble: `tdc_code`=0x0000FEFF, k=0. Required: tap count 8 without the macro, 15 with it; `err_bubble`=1 in both builds.
- Backpressure: hold `res_ready`=0 for 10 cycles after `res_valid`, with `cmd_start` pulsed meanwhile. Required: outputs stable and `busy`=1; no new run starts; `res_ready`=1 returns the block to IDLE.
- Reset mid-run: drive `rst_n` low during SETTLE. Required: `tdc_start` drops with no clock edge; after release `busy`=0 and `res_valid`=0.
